modexp_ctrl: RTL and testbench

- Sequencer that computes result = base^exp mod p, with p = 2^94 - 3, by left-to-right square-and-multiply.
- Drives one shared combinational modmul instance and holds the accumulator and operand registers around it.
- Sits between the key-schedule/protocol FSM and the modular multiplier; one exponentiation runs at a time under a start/busy/done handshake.

---
 rtl/modexp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod (2^94 - 3) around one shared modmul.
// Optional MODEXP_CONST_TIME_EN: every exponent bit runs SQUARE then MULT, with unused products sunk into a dummy register.

module modexp_modmul (
    input  logic [93:0] a_i,
    input  logic [93:0] b_i,
    output logic [93:0] p_o
);
    localparam logic [94:0] P = {1'b0, {94{1'b1}}} - 95'd2;

    logic [187:0] prod;
    logic [96:0]  fold1;
    logic [94:0]  fold2;

    // 2^94 == 3 (mod p): fold the high half down twice, then one conditional subtract.
    always_comb begin
        prod  = {94'd0, a_i} * {94'd0, b_i};
        fold1 = {3'd0, prod[93:0]} + 97'(prod[187:94]) * 97'd3;
        fold2 = {1'b0, fold1[93:0]} + 95'(fold1[96:94]) * 95'd3;
        p_o   = (fold2 >= P) ? 94'(fold2 - P) : fold2[93:0];
    end
endmodule

module modexp_ctrl #(
    parameter int EXP_W   = 94,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [93:0]      base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [93:0]      result,
    output logic [1:0]       dbg_state_o
);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    // Handshake: start is taken only when not busy (IDLE or DONE); busy covers the whole
    // operation; done pulses one cycle with result already updated; result holds until next start.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SQUARE = 2'd1,
        S_MULT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [93:0]        acc_q, acc_d;
    logic [93:0]        base_q, base_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [93:0]        result_q, result_d;
    logic               done_q, done_d;
`ifdef MODEXP_CONST_TIME_EN
    logic [93:0]        dummy_q, dummy_d;
`endif

    logic [93:0] mul_a, mul_b, mul_p;
    logic        op_last;

    modexp_modmul u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    assign op_last     = (cnt_q == 2'(MUL_LAT));
    assign busy        = (state_q == S_SQUARE) || (state_q == S_MULT);
    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        mul_a    = 94'd0;
        mul_b    = 94'd0;
`ifdef MODEXP_CONST_TIME_EN
        dummy_d  = dummy_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    acc_d   = 94'd1;
                    idx_d   = IDX_W'(EXP_W - 1);
                    cnt_d   = 2'd0;
                    state_d = S_SQUARE;
                end
            end
            S_SQUARE: begin
                mul_a = acc_q;
                mul_b = acc_q;
                if (op_last) begin
                    acc_d = mul_p;
                    cnt_d = 2'd0;
`ifdef MODEXP_CONST_TIME_EN
                    state_d = S_MULT;
`else
                    if (exp_q[idx_q]) begin
                        state_d = S_MULT;
                    end else if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_MULT: begin
                mul_a = acc_q;
                mul_b = base_q;
                if (op_last) begin
`ifdef MODEXP_CONST_TIME_EN
                    if (exp_q[idx_q]) begin
                        acc_d = mul_p;
                    end else begin
                        dummy_d = mul_p;
                    end
`else
                    acc_d = mul_p;
`endif
                    cnt_d = 2'd0;
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_SQUARE;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= 94'd0;
            base_q   <= 94'd0;
            exp_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= 2'd0;
            result_q <= 94'd0;
            done_q   <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
            dummy_q  <= 94'd0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef MODEXP_CONST_TIME_EN
            dummy_q  <= dummy_d;
`endif
        end
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: two instances (MUL_LAT 0 and 2) checked every cycle against a
// timeline/arithmetic model, plus directed literal cases, reset abort and back-to-back restart.

module tb_modexp_ctrl;
    localparam int EXP_W = 94;
    localparam logic [93:0] P   = {94{1'b1}} - 94'd2;
    localparam logic [93:0] PM1 = P - 94'd1;
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             st   [2];
    logic [93:0]      bs   [2];
    logic [EXP_W-1:0] ex   [2];
    logic             busy [2];
    logic             done [2];
    logic [93:0]      res  [2];
    logic [1:0]       dbg  [2];

    modexp_ctrl #(.EXP_W(EXP_W), .MUL_LAT(0)) u_lat0 (
        .clk(clk), .reset(rst), .start(st[0]), .base(bs[0]), .exp(ex[0]),
        .busy(busy[0]), .done(done[0]), .result(res[0]), .dbg_state_o(dbg[0])
    );
    modexp_ctrl #(.EXP_W(EXP_W), .MUL_LAT(2)) u_lat2 (
        .clk(clk), .reset(rst), .start(st[1]), .base(bs[1]), .exp(ex[1]),
        .busy(busy[1]), .done(done[1]), .result(res[1]), .dbg_state_o(dbg[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;

    task automatic check(input string name, input logic [93:0] act, input logic [93:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // reference arithmetic
    function automatic logic [93:0] mulmod(input logic [93:0] a, input logic [93:0] b);
        logic [187:0] t;
        t = {94'd0, a} * {94'd0, b};
        t = t % {94'd0, P};
        return t[93:0];
    endfunction

    function automatic logic [93:0] powmod(input logic [93:0] b, input logic [EXP_W-1:0] e);
        logic [93:0] r, sq;
        r  = 94'd1;
        sq = b;
        for (int i = 0; i < EXP_W; i++) begin
            if (e[i]) r = mulmod(r, sq);
            sq = mulmod(sq, sq);
        end
        return r;
    endfunction

    function automatic int n_ops(input logic [EXP_W-1:0] e);
        return CT ? 2 * EXP_W : EXP_W + $countones(e);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic [93:0] rnd_base();
        logic [95:0] r;
        logic [93:0] b;
        r = {$urandom, $urandom, $urandom};
        b = r[93:0];
        if (b >= P) b = b - P;
        case ($urandom_range(0, 7))
            0: b = PM1;
            1: b = 94'd0;
            2: b = 94'd1;
            default: ;
        endcase
        return b;
    endfunction

    function automatic logic [EXP_W-1:0] rnd_exp();
        logic [95:0] r;
        logic [EXP_W-1:0] e;
        r = {$urandom, $urandom, $urandom};
        e = r[EXP_W-1:0];
        case ($urandom_range(0, 3))
            0: e = EXP_W'($urandom_range(0, 255));
            1: e = {EXP_W{1'b1}};
            2: e = EXP_W'(1) << $urandom_range(0, EXP_W - 1);
            default: ;
        endcase
        return e;
    endfunction

    // scoreboard: one expected result per accepted start, released at its done edge
    logic [93:0] exp_q [2][$];
    longint      end_e [2];
    logic        m_busy[2];
    logic        m_done[2];
    logic [93:0] m_res [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                end_e[i]  = -100;
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_res[i]  = 94'd0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                if (exp_q[i].size() > 0 && cyc == end_e[i] + 1) begin
                    m_res[i]  = exp_q[i].pop_front();
                    m_done[i] = 1'b1;
                end
                if (st[i] && cyc > end_e[i]) begin
                    exp_q[i].push_back(powmod(bs[i], ex[i]));
                    end_e[i] = cyc + longint'(n_ops(ex[i]) * (lat_of(i) + 1));
                end
                m_busy[i] = (exp_q[i].size() > 0) && (cyc < end_e[i]);
            end
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy%0d", i), 94'(busy[i]), 94'(m_busy[i]));
            check($sformatf("done%0d", i), 94'(done[i]), 94'(m_done[i]));
            check($sformatf("result%0d", i), res[i], m_res[i]);
        end
    end

    // driver tasks
    task automatic wait_done(input int i, input int limit, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done[i] && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!done[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within %0d cycles (got 0 expected 1)", name, limit);
        end
    endtask

    task automatic run_one(input int i, input logic [93:0] b, input logic [EXP_W-1:0] e,
                           input int want_lat, input logic [93:0] want_res, input string name);
        longint e0;
        @(negedge clk);
        st[i] = 1'b1;
        bs[i] = b;
        ex[i] = e;
        e0 = cyc + 1;
        @(negedge clk);
        st[i] = 1'b0;
        bs[i] = rnd_base();
        ex[i] = rnd_exp();
        wait_done(i, 2000, name);
        check({name, "_lat"}, 94'(cyc - e0), 94'(want_lat));
        check({name, "_res"}, res[i], want_res);
    endtask

    initial begin
        longint c1, c2;
        int n_d;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            bs[i] = 94'd0;
            ex[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_busy%0d", i), 94'(busy[i]), 94'd0);
            check($sformatf("rst_done%0d", i), 94'(done[i]), 94'd0);
            check($sformatf("rst_result%0d", i), res[i], 94'd0);
        end
        rst = 1'b0;

        // pin the model
        check("model_2^10", powmod(94'd2, EXP_W'(10)), 94'd1024);
        check("model_5^0", powmod(94'd5, EXP_W'(0)), 94'd1);
        check("model_0^5", powmod(94'd0, EXP_W'(5)), 94'd0);
        check("model_pm1^2", powmod(PM1, EXP_W'(2)), 94'd1);
        check("model_pm1^3", powmod(PM1, EXP_W'(3)), PM1);
        check("model_3^4", powmod(94'd3, EXP_W'(4)), 94'd81);

        // directed, MUL_LAT=0
        run_one(0, 94'd2, EXP_W'(10), CT ? 189 : 97, 94'd1024, "b2e10");
        run_one(0, 94'd5, EXP_W'(0), CT ? 189 : 95, 94'd1, "b5e0");
        run_one(0, 94'd0, EXP_W'(5), CT ? 189 : 97, 94'd0, "b0e5");
        run_one(0, PM1, EXP_W'(2), CT ? 189 : 96, 94'd1, "pm1e2");
        run_one(0, PM1, EXP_W'(3), CT ? 189 : 97, PM1, "pm1e3");
        run_one(0, 94'd7, EXP_W'(1), CT ? 189 : 96, 94'd7, "b7e1");
        run_one(0, 94'd7, {1'b0, {(EXP_W-1){1'b1}}}, CT ? 189 : 188,
                powmod(94'd7, {1'b0, {(EXP_W-1){1'b1}}}), "b7e_ones");

        // directed, MUL_LAT=2
        run_one(1, 94'd3, EXP_W'(4), CT ? 565 : 286, 94'd81, "l2_b3e4");

        // start held through the run and into the done cycle: back-to-back restart
        @(negedge clk);
        st[1] = 1'b1;
        bs[1] = 94'd3;
        ex[1] = EXP_W'(5);
        wait_done(1, 1000, "hold1");
        c1 = cyc;
        check("hold1_res", res[1], 94'd243);
        wait_done(1, 1000, "hold2");
        c2 = cyc;
        check("hold_gap", 94'(c2 - c1), 94'(CT ? 565 : 289));
        check("hold2_res", res[1], 94'd243);
        st[1] = 1'b0;
        wait_done(1, 1000, "hold3");
        check("hold3_res", res[1], 94'd243);

        // reset mid-run aborts without a done pulse
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b1;
            bs[i] = rnd_base();
            ex[i] = {EXP_W{1'b1}};
        end
        @(negedge clk);
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (39) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_busy%0d", i), 94'(busy[i]), 94'd0);
            check($sformatf("abort_done%0d", i), 94'(done[i]), 94'd0);
            check($sformatf("abort_result%0d", i), res[i], 94'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_d = 0;
        repeat (700) begin
            @(negedge clk);
            if (done[0] || done[1]) n_d++;
        end
        check("no_done_after_abort", 94'(n_d), 94'd0);
        run_one(0, 94'd2, EXP_W'(10), CT ? 189 : 97, 94'd1024, "post_rst0");
        run_one(1, 94'd3, EXP_W'(4), CT ? 565 : 286, 94'd81, "post_rst1");

        // random traffic: starts while busy must be ignored, operands change freely
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                bs[i] = rnd_base();
                ex[i] = rnd_exp();
            end
        end
        @(negedge clk);
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (1200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
